// File: rtl/puf_crp_driver.sv
// Purpose: challenge-side driver for one arbiter PUF line; LFSR challenges, clear/launch sequencing, response packing.
// Latency: CLR_CYC+SETTLE_CYC+1 cycles per bit; resp_valid rises RESP_W bit-times after start is accepted.
// Backpressure: resp_valid/resp_ready; the FSM parks in OUT, no evaluation runs and the LFSR holds while stalled.
//
// Ports:
//   clk, clr            system clock, synchronous active-high reset
//   seed_load, seed     load LFSR seed (IDLE only); seed 0 is replaced by 1
//   start, cont         begin a word (IDLE only); cont at handshake chains the next word
//   puf_clk, puf_clr    launch and clear strobes to the PUF line (never both high)
//   puf_chal            challenge to the line (the LFSR register itself)
//   puf_r               asynchronous response from the line
//   busy                high outside IDLE
//   resp_valid/ready    output word handshake; resp_data is first-sampled-bit-MSB
`timescale 1ns/1ps

module puf_crp_driver #(
  parameter int CHAL_W     = 32,
  parameter int RESP_W     = 32,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              seed_load,
  input  logic [CHAL_W-1:0] seed,
  input  logic              start,
  input  logic              cont,
  output logic              puf_clk,
  output logic              puf_clr,
  output logic [CHAL_W-1:0] puf_chal,
  input  logic              puf_r,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data
);

  localparam int CNT_W   = $clog2(RESP_W + 1);
  localparam int CYC_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CNT_W-1:0]  RESP_LAST   = CNT_W'(RESP_W - 1);
  localparam logic [CYC_W-1:0]  CLR_LAST    = CYC_W'(CLR_CYC - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CHAL_W-1:0] LFSR_ONE    = CHAL_W'(1);
  // Galois right-shift taps for x^32+x^22+x^2+x+1.
  localparam logic [CHAL_W-1:0] LFSR_POLY   = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_SAMPLE,
    S_OUT
  } state_t;

  state_t            state_q;
  logic [CHAL_W-1:0] lfsr_q, lfsr_d;
  logic [RESP_W-1:0] shift_q, shift_d;
  logic [RESP_W-1:0] resp_data_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [1:0]        r_sync_q;
  logic              puf_clk_q, puf_clr_q, busy_q, resp_valid_q;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[CHAL_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_POLY;
    end
    // Shift-left form keeps RESP_W=1 legal; the oldest bit simply falls off.
    shift_d = (shift_q << 1) | RESP_W'(r_sync_q[1]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      puf_clr_q    <= 1'b1;
      puf_clk_q    <= 1'b0;
      lfsr_q       <= LFSR_ONE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      bit_cnt_q    <= '0;
      cyc_q        <= '0;
      r_sync_q     <= 2'b00;
    end else begin
      r_sync_q <= {r_sync_q[0], puf_r};

      unique case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q <= (seed == '0) ? LFSR_ONE : seed;
          end else if (start) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
          end
        end

        S_CLEAR: begin
          if (cyc_q == CLR_LAST) begin
            cyc_q     <= '0;
            state_q   <= S_LAUNCH;
            // Drop clear and raise launch on the same edge so they never overlap.
            puf_clr_q <= 1'b0;
            puf_clk_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        S_LAUNCH: begin
          if (cyc_q == SETTLE_LAST) begin
            cyc_q     <= '0;
            state_q   <= S_SAMPLE;
            puf_clk_q <= 1'b0;
            puf_clr_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        S_SAMPLE: begin
          shift_q   <= shift_d;
          lfsr_q    <= lfsr_d;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == RESP_LAST) begin
            resp_data_q  <= shift_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end else begin
            state_q <= S_CLEAR;
          end
        end

        S_OUT: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            if (cont) begin
              state_q <= S_CLEAR;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          puf_clk_q <= 1'b0;
          puf_clr_q <= 1'b1;
        end
      endcase
    end
  end

  assign puf_clk    = puf_clk_q;
  assign puf_clr    = puf_clr_q;
  assign puf_chal   = lfsr_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_puf_crp_driver.sv
`timescale 1ns/1ps

module tb_puf_crp_driver;

  logic        clk = 1'b0;
  logic        clr;
  logic        seed_load;
  logic [31:0] seed;
  logic        start;
  logic        cont;
  logic        puf_clk;
  logic        puf_clr;
  logic [31:0] puf_chal;
  logic        puf_r;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  puf_crp_driver #(
    .CHAL_W(32), .RESP_W(32), .CLR_CYC(2), .SETTLE_CYC(8)
  ) dut (
    .clk(clk), .clr(clr), .seed_load(seed_load), .seed(seed), .start(start), .cont(cont),
    .puf_clk(puf_clk), .puf_clr(puf_clr), .puf_chal(puf_chal), .puf_r(puf_r),
    .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  // Line model: the arbiter latches C[0] on the launch edge, clear forces it low.
  logic line_r = 1'b0;
  always @(posedge puf_clk or posedge puf_clr) begin
    if (puf_clr) line_r <= 1'b0;
    else         line_r <= puf_chal[0];
  end
  assign puf_r = line_r;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_lfsr;
  logic [31:0] first_word;
  int          n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Predict one word from the reference LFSR and advance it by 32 steps.
  task automatic push_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w          = {w[30:0], model_lfsr[0]};
      model_lfsr = lfsr_step(model_lfsr);
    end
    sb_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (resp_valid !== 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  // Scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (clr === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", resp_data, 64'hx);
      end else begin
        check("word", resp_data, sb_q.pop_front());
      end
    end
  end

  // Per-cycle invariants.
  logic        prev_clk  = 1'b0;
  logic [31:0] prev_chal = '0;
  always @(negedge clk) begin
    check("clk_clr_excl", puf_clk & puf_clr, 0);
    if (puf_clk === 1'b1 && prev_clk === 1'b1) begin
      check("chal_stable", puf_chal, prev_chal);
    end
    prev_clk  = puf_clk;
    prev_chal = puf_chal;
  end

  initial begin
    clr = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0; cont = 1'b0; resp_ready = 1'b0;
    model_lfsr = 32'h1;
    repeat (3) tick();
    check("rst_puf_clr", puf_clr, 1);
    check("rst_puf_clk", puf_clk, 0);
    check("rst_chal", puf_chal, 32'h1);
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    clr = 1'b0;
    tick();

    // Seed 1, first word.
    seed = 32'h1; seed_load = 1'b1; tick(); seed_load = 1'b0;
    model_lfsr = 32'h1;
    check("seed_chal", puf_chal, 32'h1);
    start = 1'b1; push_word(); first_word = sb_q[sb_q.size()-1]; tick(); start = 1'b0;
    check("busy_w1", busy, 1);
    wait_valid(n);
    check("lat_w1", n, 352);

    // Backpressure: word, challenge and strobes frozen.
    check("out_chal", puf_chal, model_lfsr);
    repeat (50) begin
      tick();
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, first_word);
      check("bp_puf_clk", puf_clk, 0);
      check("bp_chal", puf_chal, model_lfsr);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    check("valid_drop", resp_valid, 0);
    check("busy_idle", busy, 0);

    // Ready without valid does nothing.
    resp_ready = 1'b1;
    repeat (3) tick();
    check("rdy_idle_busy", busy, 0);
    check("rdy_idle_valid", resp_valid, 0);

    // Back-to-back words with cont=1.
    cont = 1'b1; start = 1'b1; push_word(); push_word(); tick(); start = 1'b0;
    wait_valid(n);
    check("lat_b2b_1", n, 352);
    tick(); cont = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("b2b_gap", n, 353);
    tick();
    check("b2b_end_busy", busy, 0);
    check("b2b_end_valid", resp_valid, 0);

    // start/seed_load while busy are ignored.
    start = 1'b1; push_word(); tick(); start = 1'b0;
    repeat (99) tick();
    start = 1'b1; seed_load = 1'b1; seed = 32'hDEAD_BEEF; tick(); start = 1'b0; seed_load = 1'b0;
    check("busy_ign", busy, 1);
    wait_valid(n);
    check("lat_ign", n, 252);
    tick();
    check("ign_end_busy", busy, 0);

    // seed_load with seed 0 and start together in IDLE.
    resp_ready = 1'b0; seed = '0; seed_load = 1'b1; start = 1'b1; tick(); seed_load = 1'b0; start = 1'b0;
    model_lfsr = 32'h1;
    check("seed0_busy", busy, 0);
    check("seed0_chal", puf_chal, 32'h1);
    tick();
    check("seed0_busy2", busy, 0);

    // Abort with clr during bit 17, then a restart reproduces the first word.
    seed = 32'h1357_9BDF; seed_load = 1'b1; tick(); seed_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (16 * 11 + 5) tick();
    check("pre_clr_busy", busy, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_puf_clr", puf_clr, 1);
    check("clr_puf_clk", puf_clk, 0);
    check("clr_valid", resp_valid, 0);
    check("clr_chal", puf_chal, 32'h1);
    sb_q.push_back(first_word);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    check("lat_restart", n, 352);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    tick();
    check("restart_busy", busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
